param_johnson_counter: RTL and testbench

Parametrised successor to the team's fixed 8-bit Johnson counter. Generalises width and adds a ring-counter mode, bidirectional stepping, count enable, parallel load, a decoded position output and a wrap pulse. Used as a phase and sequence generator for multi-phase timing and LED/scan sequencing in the lab designs. Single clock domain; all outputs registered or decoded directly from the state register.

---
 rtl/johnson_pkg.sv | 20 ++
 rtl/johnson_pos_decode.sv | 76 +++++++
 rtl/param_johnson_counter.sv | 94 +++++++++
 tb/tb_param_johnson_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson/ring counter family: mode and direction
// encodings plus the sequence period helper.
package johnson_pkg;

    localparam int MODE_JOHNSON = 0;
    localparam int MODE_RING    = 1;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Number of distinct legal states in one full sequence.
    function automatic int period(input int width, input int mode);
        if (mode == MODE_RING) begin
            return width;
        end else begin
            return 2 * width;
        end
    endfunction

endpackage

// File: rtl/johnson_pos_decode.sv
// Combinational decoder: maps a Johnson or ring counter state onto its
// position in the sequence and flags states that are not in the sequence.
// Illegal states decode to position 0.
module johnson_pos_decode
    import johnson_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  MODE  = 0,
    localparam int PW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [PW-1:0]    o_pos,
    output logic             o_illegal
);

    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW:0]      ONE_CNT = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]      ZERO_CNT = {(PW+1){1'b0}};
    localparam logic [PW:0]      TWO_W   = (PW+1)'(2 * WIDTH);

    logic [WIDTH-1:0] w_inv;
    logic             w_low_run;
    logic             w_high_run;
    logic             w_legal;
    logic [PW:0]      w_ones;
    logic [PW-1:0]    w_idx;
    logic [PW:0]      w_back;

    // A run of ones anchored at bit 0 (including all-zeros and all-ones) has
    // no set bit above a clear bit; the high-anchored run is the same test on
    // the inverted state.
    assign w_inv      = ~i_state;
    assign w_low_run  = ((i_state & (i_state + ONE_W)) == {WIDTH{1'b0}});
    assign w_high_run = ((w_inv & (w_inv + ONE_W)) == {WIDTH{1'b0}});
    assign w_back     = TWO_W - w_ones;

    // Population count and index of the highest set bit.
    always_comb begin
        w_ones = ZERO_CNT;
        w_idx  = {PW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + {{PW{1'b0}}, i_state[i]};
            if (i_state[i]) begin
                w_idx = PW'(i);
            end else begin
                w_idx = w_idx;
            end
        end
    end

    // Legality and position according to the counter flavour.
    always_comb begin
        w_legal = 1'b0;
        o_pos   = {PW{1'b0}};
        if (MODE == MODE_RING) begin
            w_legal = (w_ones == ONE_CNT);
            if (w_legal) begin
                o_pos = w_idx;
            end else begin
                o_pos = {PW{1'b0}};
            end
        end else begin
            w_legal = w_low_run | w_high_run;
            if (!w_legal || (w_ones == ZERO_CNT)) begin
                o_pos = {PW{1'b0}};
            end else if (i_state[0]) begin
                o_pos = w_ones[PW-1:0];
            end else begin
                o_pos = w_back[PW-1:0];
            end
        end
    end

    assign o_illegal = ~w_legal;

endmodule

// File: rtl/param_johnson_counter.sv
// Parametrised Johnson / ring counter with direction, enable, parallel load,
// decoded position and wrap pulse.
// Optional build macro SELF_CORRECT_EN: when defined, the illegal output is
// live and an enabled step out of an illegal state reloads the reset state.
// When undefined, illegal reads 0 and illegal states shift like any other.
module param_johnson_counter
    import johnson_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  MODE  = 0,
    localparam int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    pos,
    output logic             wrap,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] RST_VAL = (MODE == MODE_RING) ?
                                           {{(WIDTH-1){1'b0}}, 1'b1} :
                                           {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_out;
    logic             r_wrap;
    logic [WIDTH-1:0] w_step;
    logic             w_dec_illegal;
    logic             w_correct_en;

`ifdef SELF_CORRECT_EN
    assign w_correct_en = 1'b1;
`else
    assign w_correct_en = 1'b0;
`endif

    // Candidate next state for one step in the requested direction.
    always_comb begin
        w_step = r_out;
        if (MODE == MODE_RING) begin
            if (dir == DIR_UP) begin
                w_step = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
            end else begin
                w_step = {r_out[0], r_out[WIDTH-1:1]};
            end
        end else begin
            if (dir == DIR_UP) begin
                w_step = {r_out[WIDTH-2:0], ~r_out[WIDTH-1]};
            end else begin
                w_step = {~r_out[0], r_out[WIDTH-1:1]};
            end
        end
    end

    // State register and wrap pulse: reset beats load, load beats step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out  <= RST_VAL;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_out  <= load_val;
            r_wrap <= 1'b0;
        end else if (en) begin
            if (w_correct_en && w_dec_illegal) begin
                r_out  <= RST_VAL;
                r_wrap <= 1'b0;
            end else begin
                r_out  <= w_step;
                r_wrap <= (w_step == RST_VAL);
            end
        end else begin
            r_out  <= r_out;
            r_wrap <= 1'b0;
        end
    end

    johnson_pos_decode #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_decode (
        .i_state   (r_out),
        .o_pos     (pos),
        .o_illegal (w_dec_illegal)
    );

    assign out     = r_out;
    assign wrap    = r_wrap;
    assign illegal = w_dec_illegal & w_correct_en;

endmodule

// File: tb/tb_param_johnson_counter.sv
// Scoreboard bench for param_johnson_counter: an 8-bit Johnson instance and a
// 4-bit ring instance run side by side. The reference model tracks sequence
// position arithmetically and pushes expected outputs; a monitor pops and
// compares after every clock edge.
module tb_param_johnson_counter;
    import johnson_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_en, a_dir, a_load;
    logic [7:0] a_lv, a_out;
    logic [3:0] a_pos;
    logic       a_wrap, a_ill;

    logic       b_reset, b_en, b_dir, b_load;
    logic [3:0] b_lv, b_out;
    logic [2:0] b_pos;
    logic       b_wrap, b_ill;

    typedef struct {
        int a_out; int a_pos; int a_wrap; int a_ill;
        int b_out; int b_pos; int b_wrap; int b_ill;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ma_v   = 0;
    int   mb_v   = 1;

    param_johnson_counter #(.WIDTH(8), .MODE(MODE_JOHNSON)) u_a (
        .clk(clk), .reset(a_reset), .en(a_en), .dir(a_dir), .load(a_load),
        .load_val(a_lv), .out(a_out), .pos(a_pos), .wrap(a_wrap), .illegal(a_ill)
    );

    param_johnson_counter #(.WIDTH(4), .MODE(MODE_RING)) u_b (
        .clk(clk), .reset(b_reset), .en(b_en), .dir(b_dir), .load(b_load),
        .load_val(b_lv), .out(b_out), .pos(b_pos), .wrap(b_wrap), .illegal(b_ill)
    );

    // Value of the sequence member at position p.
    function automatic int val_at(int w, int m, int p);
        int mask;
        mask = (1 << w) - 1;
        if (m == MODE_RING) return 1 << p;
        if (p == 0) return 0;
        if (p <= w) return (1 << p) - 1;
        return mask & ~((1 << (p - w)) - 1);
    endfunction

    // Position of v in the sequence, or -1 when v is not a member.
    function automatic int find_pos(int w, int m, int v);
        for (int p = 0; p < period(w, m); p++) begin
            if (val_at(w, m, p) == v) return p;
        end
        return -1;
    endfunction

    // Raw shift rule, only needed for states outside the sequence.
    function automatic int shift_raw(int w, int m, bit d, int v);
        int mask, msb, lsb;
        mask = (1 << w) - 1;
        msb  = (v >> (w - 1)) & 1;
        lsb  = v & 1;
        if (m == MODE_RING) begin
            if (!d) return ((v << 1) & mask) | msb;
            return (v >> 1) | (lsb << (w - 1));
        end
        if (!d) return ((v << 1) & mask) | (msb ^ 1);
        return (v >> 1) | ((lsb ^ 1) << (w - 1));
    endfunction

    function automatic int next_v(int w, int m, bit rst, bit en, bit d, bit ld,
                                  int lv, int v, output int wr);
        int p, per, np, nv;
        wr = 0;
        if (!rst) return val_at(w, m, 0);
        if (ld) return lv;
        if (!en) return v;
        p = find_pos(w, m, v);
        if (p >= 0) begin
            per = period(w, m);
            np  = d ? (p + per - 1) % per : (p + 1) % per;
            wr  = (np == 0) ? 1 : 0;
            return val_at(w, m, np);
        end
`ifdef SELF_CORRECT_EN
        return val_at(w, m, 0);
`else
        nv = shift_raw(w, m, d, v);
        wr = (nv == val_at(w, m, 0)) ? 1 : 0;
        return nv;
`endif
    endfunction

    function automatic int exp_pos(int w, int m, int v);
        int p;
        p = find_pos(w, m, v);
        return (p < 0) ? 0 : p;
    endfunction

    function automatic int exp_ill(int w, int m, int v);
`ifdef SELF_CORRECT_EN
        return (find_pos(w, m, v) < 0) ? 1 : 0;
`else
        return (w + m + v) * 0;
`endif
    endfunction

    task automatic tick(input bit ar, input bit ae, input bit ad, input bit al, input int alv,
                        input bit br, input bit be, input bit bd, input bit bl, input int blv);
        exp_t e;
        int   wa, wb;
        @(negedge clk);
        a_reset = ar; a_en = ae; a_dir = ad; a_load = al; a_lv = alv[7:0];
        b_reset = br; b_en = be; b_dir = bd; b_load = bl; b_lv = blv[3:0];
        ma_v = next_v(8, MODE_JOHNSON, ar, ae, ad, al, alv & 8'hFF, ma_v, wa);
        mb_v = next_v(4, MODE_RING, br, be, bd, bl, blv & 4'hF, mb_v, wb);
        e.a_out = ma_v; e.a_pos = exp_pos(8, MODE_JOHNSON, ma_v);
        e.a_wrap = wa;  e.a_ill = exp_ill(8, MODE_JOHNSON, ma_v);
        e.b_out = mb_v; e.b_pos = exp_pos(4, MODE_RING, mb_v);
        e.b_wrap = wb;  e.b_ill = exp_ill(4, MODE_RING, mb_v);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("a_out",  32'(a_out),  e.a_out);
                chk("a_pos",  32'(a_pos),  e.a_pos);
                chk("a_wrap", 32'(a_wrap), e.a_wrap);
                chk("a_ill",  32'(a_ill),  e.a_ill);
                chk("b_out",  32'(b_out),  e.b_out);
                chk("b_pos",  32'(b_pos),  e.b_pos);
                chk("b_wrap", 32'(b_wrap), e.b_wrap);
                chk("b_ill",  32'(b_ill),  e.b_ill);
            end
        end
    end

    // Stimulus: directed scenarios then randomized traffic.
    initial begin
        int alv, blv;
        a_reset = 1'b0; a_en = 1'b0; a_dir = 1'b0; a_load = 1'b0; a_lv = 8'h00;
        b_reset = 1'b0; b_en = 1'b0; b_dir = 1'b0; b_load = 1'b0; b_lv = 4'h0;

        // reset for two cycles
        repeat (2) tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // full Johnson up cycle; ring: 5 up steps then 1 down step
        for (int i = 0; i < 16; i++) tick(1, 1, 0, 0, 0, 1, i < 6, i == 5, 0, 0);
        // load 0x07 then step down four times
        tick(1, 0, 0, 1, 8'h07, 1, 0, 0, 0, 0);
        repeat (4) tick(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        // load wins over en; reset wins over load
        tick(1, 1, 0, 1, 8'h0F, 1, 1, 0, 1, 4'h4);
        tick(0, 1, 0, 1, 8'h0F, 0, 1, 0, 1, 4'h4);
        // mid-count reset at 0x3F, then resume counting
        tick(1, 0, 0, 1, 8'h3F, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) tick(1, 1, 0, 0, 0, 1, 1, 1, 0, 0);
        // illegal loads followed by steps
        tick(1, 0, 0, 1, 8'h05, 1, 0, 0, 1, 4'h3);
        repeat (2) tick(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        // direction reversal mid-sequence
        tick(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 1, 1, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            alv = ($urandom % 2 == 0) ? val_at(8, MODE_JOHNSON, $urandom % 16) : $urandom % 256;
            blv = ($urandom % 2 == 0) ? val_at(4, MODE_RING, $urandom % 4) : $urandom % 16;
            tick($urandom % 20 != 0, $urandom % 4 != 0, $urandom % 2 == 1, $urandom % 10 == 0, alv,
                 $urandom % 20 != 0, $urandom % 4 != 0, $urandom % 2 == 1, $urandom % 10 == 0, blv);
        end

        repeat (3) @(negedge clk);
        chk("queue_drain", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
